// File: rtl/wr_burst_feeder.sv
// Buffers an input word stream in a FIFO and issues fixed-length write burst
// requests, stepping the burst address through a wrapping region.
module wr_burst_feeder #(
  parameter int unsigned ADDR_WIDTH  = 26,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter logic [7:0]  BURST_LEN   = 8'd8,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned ADDR_STEP   = 16,
  parameter int unsigned REGION_SIZE = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init_end,
  input  logic                          in_sof,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  output logic                          wr_trig,
  output logic [7:0]                    wr_len,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_data_en,
  input  logic                          wr_ready,
  input  logic                          wr_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  localparam logic [LW-1:0]         FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]         BURST_LVL = LW'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP_A    = ADDR_WIDTH'(ADDR_STEP);
  // One extra bit so the region end can be compared without truncation.
  localparam logic [ADDR_WIDTH:0]   LIMIT_A   = (ADDR_WIDTH+1)'(BASE_ADDR + REGION_SIZE);

  typedef enum logic [1:0] {IDLE, TRIG, BUSY} state_t;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] wr_data_q;

  state_t                state_q;
  logic                  trig_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  restart_q, restart_d;
  logic                  over_q, under_q;

  logic                  push, pop, start, consume;
  logic [ADDR_WIDTH-1:0] addr_inc, addr_next;

  assign in_ready   = (level_q != FULL_LVL);
  assign fifo_level = level_q;
  assign wr_data    = wr_data_q;
  assign wr_trig    = trig_q;
  assign wr_addr    = addr_q;
  assign wr_len     = BURST_LEN;
  assign overflow   = over_q;
  assign underrun   = under_q;

  always_comb begin
    push    = in_valid && in_ready;
    pop     = wr_data_en && (level_q != '0);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    start     = init_end && wr_ready && (level_q >= BURST_LVL);
    addr_inc  = addr_q + STEP_A;
    addr_next = ({1'b0, addr_inc} >= LIMIT_A) ? BASE_A : addr_inc;
    // The restart request is consumed in IDLE (before any trigger) or at wr_done;
    // a start-of-frame push in the same cycle re-arms it for the next update.
    consume   = (state_q == IDLE) || ((state_q == BUSY) && wr_done);
    restart_d = (restart_q && !consume) || (push && in_sof);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      wr_data_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      if (pop) wr_data_q <= mem_q[rptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      trig_q    <= 1'b0;
      addr_q    <= BASE_A;
      restart_q <= 1'b0;
      over_q    <= 1'b0;
      under_q   <= 1'b0;
    end else begin
      over_q    <= over_q || (in_valid && !in_ready);
      under_q   <= under_q || (wr_data_en && (level_q == '0));
      restart_q <= restart_d;
      case (state_q)
        IDLE: begin
          if (restart_q) addr_q <= BASE_A;
          if (start) begin
            state_q <= TRIG;
            trig_q  <= 1'b1;
          end
        end
        TRIG: begin
          trig_q  <= 1'b0;
          state_q <= BUSY;
        end
        BUSY: begin
          if (wr_done) begin
            state_q <= IDLE;
            addr_q  <= restart_q ? BASE_A : addr_next;
          end
        end
        default: begin
          state_q <= IDLE;
          trig_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wr_burst_feeder.sv
// Bench for wr_burst_feeder: a directed vector table, hand-written corner
// sequences, and a random phase checked every cycle against a queue-based model.
module tb_wr_burst_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_end = 1'b0, in_sof = 1'b0, in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, wr_trig;
  logic [7:0]  wr_len;
  logic [25:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_data_en = 1'b0, wr_ready = 1'b0, wr_done = 1'b0;
  logic [6:0]  fifo_level;
  logic        overflow, underrun;

  wr_burst_feeder #(
    .ADDR_WIDTH(26), .DATA_WIDTH(32), .FIFO_DEPTH(64), .BURST_LEN(8'd8),
    .BASE_ADDR(0), .ADDR_STEP(16), .REGION_SIZE(4096)
  ) dut (
    .clk(clk), .rst(rst), .init_end(init_end), .in_sof(in_sof),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_trig(wr_trig), .wr_len(wr_len), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_data_en(wr_data_en), .wr_ready(wr_ready), .wr_done(wr_done),
    .fifo_level(fifo_level), .overflow(overflow), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO as a queue, burst bookkeeping as plain flags.
  logic [31:0] q[$];
  logic [31:0] m_data;
  logic        m_over, m_under, m_trig, m_outstanding, m_restart;
  int          m_addr;

  task automatic model_reset();
    q.delete();
    m_data = '0; m_over = 0; m_under = 0; m_trig = 0;
    m_outstanding = 0; m_restart = 0; m_addr = 0;
  endtask

  task automatic model_edge();
    int  lvl;
    bit  do_push, do_pop, rs, used;
    lvl     = q.size();
    do_pop  = wr_data_en && lvl != 0;
    do_push = in_valid && lvl != 64;
    if (wr_data_en && lvl == 0) m_under = 1;
    if (in_valid && lvl == 64)  m_over = 1;
    if (do_pop)  m_data = q.pop_front();
    if (do_push) q.push_back(in_data);
    rs = m_restart; used = 0;
    if (!m_outstanding) begin
      if (rs) begin m_addr = 0; used = 1; end
      if (init_end && wr_ready && lvl >= 8) begin m_trig = 1; m_outstanding = 1; end
    end else if (m_trig) begin
      m_trig = 0;
    end else if (wr_done) begin
      m_outstanding = 0;
      m_addr = rs ? 0 : ((m_addr + 16 >= 4096) ? 0 : m_addr + 16);
      used = 1;
    end
    m_restart = (rs && !used) || (do_push && in_sof);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("level",    64'(fifo_level), 64'(q.size()));
    chk("in_ready", 64'(in_ready),   64'(q.size() != 64));
    chk("wr_trig",  64'(wr_trig),    64'(m_trig));
    chk("wr_addr",  64'(wr_addr),    64'(m_addr));
    chk("wr_len",   64'(wr_len),     64'd8);
    chk("wr_data",  64'(wr_data),    64'(m_data));
    chk("overflow", 64'(overflow),   64'(m_over));
    chk("underrun", 64'(underrun),   64'(m_under));
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_sof = 0; wr_data_en = 0; wr_done = 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_all();
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1; in_data = 32'(base + i);
      step();
    end
    in_valid = 0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      wr_data_en = 1;
      step();
    end
    wr_data_en = 0;
  endtask

  task automatic wait_trig(input int exp_addr);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (wr_trig) seen = 1;
    end
    chk("trig_seen", 64'(seen), 64'd1);
    if (seen) begin
      chk("burst_addr", 64'(wr_addr), 64'(exp_addr));
      chk("burst_len",  64'(wr_len),  64'd8);
    end
  endtask

  // One full burst: fill, trigger, optional start-of-frame push while busy,
  // drain, wr_done.
  task automatic do_burst(input int exp_addr, input bit sof_word);
    push_n(8, exp_addr * 4);
    wait_trig(exp_addr);
    step();
    if (sof_word) begin
      in_valid = 1; in_sof = 1; in_data = 32'hC0DE_0000;
      step();
      in_valid = 0; in_sof = 0;
      pop_n(9);
    end else begin
      pop_n(8);
    end
    wr_done = 1; step(); wr_done = 0;
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        en;
    logic        done;
    int          lvl;
    logic        trig;
    int          addr;
    logic [31:0] dat;
  } vec_t;

  function automatic vec_t mkv(input logic v, input int d, input logic e, input logic dn,
                               input int l, input logic t, input int a, input int x);
    vec_t r;
    r.valid = v; r.data = 32'(d); r.en = e; r.done = dn;
    r.lvl = l; r.trig = t; r.addr = a; r.dat = 32'(x);
    return r;
  endfunction

  vec_t tv[20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) tv[i] = mkv(1, i + 1, 0, 0, i + 1, 0, 0, 0);
    tv[8] = mkv(0, 0, 0, 0, 8, 1, 0, 0);
    tv[9] = mkv(0, 0, 0, 0, 8, 0, 0, 0);
    for (int k = 0; k < 8; k++) tv[10 + k] = mkv(0, 0, 1, 0, 7 - k, 0, 0, k + 1);
    tv[18] = mkv(0, 0, 0, 1, 0, 0, 16, 8);
    tv[19] = mkv(0, 0, 0, 0, 0, 0, 16, 8);

    // Reset values
    do_reset();
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ready", 64'(in_ready),   64'd1);
    chk("rst_trig",  64'(wr_trig),    64'd0);
    chk("rst_len",   64'(wr_len),     64'd8);
    chk("rst_addr",  64'(wr_addr),    64'd0);
    chk("rst_data",  64'(wr_data),    64'd0);
    chk("rst_ovf",   64'(overflow),   64'd0);
    chk("rst_und",   64'(underrun),   64'd0);

    // First burst from the vector table
    init_end = 1; wr_ready = 1;
    for (int i = 0; i < 20; i++) begin
      in_valid = tv[i].valid; in_data = tv[i].data;
      wr_data_en = tv[i].en; wr_done = tv[i].done;
      step();
      chk("tv_level", 64'(fifo_level), 64'(tv[i].lvl));
      chk("tv_trig",  64'(wr_trig),    64'(tv[i].trig));
      chk("tv_addr",  64'(wr_addr),    64'(tv[i].addr));
      chk("tv_data",  64'(wr_data),    64'(tv[i].dat));
    end
    idle_inputs();

    // Below threshold, then init_end low
    do_reset();
    init_end = 1; wr_ready = 1;
    push_n(7, 100);
    repeat (4) begin step(); chk("no_trig_7", 64'(wr_trig), 64'd0); end
    init_end = 0;
    push_n(3, 200);
    repeat (4) begin step(); chk("no_trig_init", 64'(wr_trig), 64'd0); end
    init_end = 1;
    wait_trig(0);

    // Overflow: 65 pushes without pops; the 65th word never appears
    do_reset();
    init_end = 0;
    push_n(65, 1000);
    chk("ovf_level", 64'(fifo_level), 64'd64);
    chk("ovf_ready", 64'(in_ready),   64'd0);
    chk("ovf_flag",  64'(overflow),   64'd1);
    pop_n(64);
    chk("ovf_last",  64'(wr_data),    64'd1063);
    pop_n(1);
    chk("ovf_nodrop", 64'(wr_data),   64'd1063);
    chk("ovf_sticky", 64'(overflow),  64'd1);

    // Simultaneous push and pop at level 5
    do_reset();
    push_n(5, 300);
    in_valid = 1; in_data = 32'd305; wr_data_en = 1;
    step();
    idle_inputs();
    chk("pp_level", 64'(fifo_level), 64'd5);
    chk("pp_data",  64'(wr_data),    64'd300);

    // Underrun leaves wr_data unchanged
    do_reset();
    push_n(1, 32'hA5);
    pop_n(1);
    chk("und_pre", 64'(underrun), 64'd0);
    pop_n(1);
    chk("und_flag", 64'(underrun), 64'd1);
    chk("und_data", 64'(wr_data),  64'hA5);
    step();
    chk("und_sticky", 64'(underrun), 64'd1);

    // Address walk across the whole region and the wrap
    do_reset();
    init_end = 1; wr_ready = 1;
    for (int b = 0; b < 257; b++) do_burst((b * 16) % 4096, 0);

    // Start-of-frame during the burst at address 32
    do_reset();
    init_end = 1; wr_ready = 1;
    do_burst(0, 0);
    do_burst(16, 0);
    do_burst(32, 1);
    chk("sof_addr", 64'(wr_addr), 64'd0);
    do_burst(0, 0);
    do_burst(16, 0);

    // Reset asserted mid-burst takes effect without a clock edge
    do_reset();
    init_end = 1; wr_ready = 1;
    push_n(8, 500);
    wait_trig(0);
    step();
    push_n(3, 600);
    #2 rst = 1;
    #1;
    model_reset();
    chk("arst_trig",  64'(wr_trig),    64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    chk("arst_ready", 64'(in_ready),   64'd1);
    chk("arst_addr",  64'(wr_addr),    64'd0);
    chk("arst_len",   64'(wr_len),     64'd8);
    chk("arst_data",  64'(wr_data),    64'd0);
    chk("arst_ovf",   64'(overflow),   64'd0);
    chk("arst_und",   64'(underrun),   64'd0);
    @(posedge clk); #1 rst = 0;
    check_all();
    push_n(7, 700);
    repeat (3) begin step(); chk("arst_notrig", 64'(wr_trig), 64'd0); end
    push_n(1, 707);
    wait_trig(0);

    // Random traffic against the model
    do_reset();
    for (int phase = 0; phase < 8; phase++) begin
      int en_pct, vl_pct;
      vl_pct = 20 + (phase * 11) % 70;
      en_pct = 80 - (phase * 17) % 70;
      for (int c = 0; c < 500; c++) begin
        in_valid   = ($urandom_range(99) < vl_pct);
        in_data    = $urandom;
        in_sof     = ($urandom_range(39) == 0);
        wr_data_en = ($urandom_range(99) < en_pct);
        wr_done    = ($urandom_range(5) == 0);
        init_end   = ($urandom_range(7) != 0);
        wr_ready   = ($urandom_range(3) != 0);
        step();
      end
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
